// File: rtl/usb_ep_rx_stream.sv
// usb_ep_rx_stream: reads a byte range out of the USB EP RX buffer and
// streams it as bytes with valid/ready/last, using a two-word prefetch.
//
// Ports:
//   clk, rst_n            clock (ep_clk) and async active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_addr byte address,
//   cmd_addr/cmd_len      cmd_len byte count (0..1023)
//   abort                 cancel the running command
//   ep_rx_addr_0/re_0     buffer word address / read enable
//   ep_rx_data_1          buffer data, one cycle after the read enable
//   out_data/valid/last   byte stream towards the sink
//   out_ready             sink accepts byte
//   done                  one-cycle completion pulse
//   busy                  command in progress (~cmd_ready)

module usb_ep_rx_stream #(
  parameter int EPDW = 16,
  localparam int LB = $clog2(EPDW/8),
  localparam int EPAW = 11 - LB
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [10:0]     cmd_addr,
  input  logic [9:0]      cmd_len,
  input  logic            abort,
  output logic [EPAW-1:0] ep_rx_addr_0,
  output logic            ep_rx_re_0,
  input  logic [EPDW-1:0] ep_rx_data_1,
  output logic [7:0]      out_data,
  output logic            out_valid,
  output logic            out_last,
  input  logic            out_ready,
  output logic            done,
  output logic            busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]      r_state;
  logic            r_ph;
  logic            r_pend;
  logic            r_v0;
  logic            r_v1;
  logic [EPDW-1:0] r_w0;
  logic [EPDW-1:0] r_w1;
  logic [10:0]     r_cur;
  logic [9:0]      r_rem;
  logic [10:0]     r_wleft;
  logic [EPAW-1:0] r_raddr;

  logic            w_fetch;
  logic            w_stream;
  logic [1:0]      w_occ;
  logic            w_issue;
  logic            w_hs;
  logic            w_lastb;
  logic            w_pop;
  logic [10:0]     w_span;
  logic [10:0]     w_nwords;

  assign w_fetch  = (r_state == S_FETCH);
  assign w_stream = (r_state == S_STREAM);

  // Words held or in flight; a new read only when a slot is free.
  assign w_occ = {1'b0, r_v0} + {1'b0, r_v1}
               + {1'b0, r_pend};

  assign w_issue = ~abort
                 & (r_wleft != 11'd0)
                 & (w_fetch | w_stream)
                 & (w_occ < 2'd2);

  assign w_hs    = out_valid & out_ready;
  assign w_lastb = (r_rem == 10'd1);

  // Head word retires on its top lane or on the final byte.
  assign w_pop = w_hs & ((&r_cur[LB-1:0]) | w_lastb);

  // Words touched by [addr, addr+len-1], counted from the start lane.
  assign w_span = 11'(cmd_addr[LB-1:0])
                + 11'(cmd_len) - 11'd1;
  assign w_nwords = (w_span >> LB) + 11'd1;

  assign cmd_ready    = (r_state == S_IDLE);
  assign busy         = ~cmd_ready;
  assign done         = (r_state == S_DONE);
  assign ep_rx_re_0   = w_issue;
  assign ep_rx_addr_0 = r_raddr;
  assign out_valid    = w_stream & r_v0;
  assign out_last     = out_valid & w_lastb;
  assign out_data     = r_w0[{r_cur[LB-1:0], 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ph    <= 1'b0;
      r_pend  <= 1'b0;
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_w0    <= '0;
      r_w1    <= '0;
      r_cur   <= '0;
      r_rem   <= '0;
      r_wleft <= '0;
      r_raddr <= '0;
    end else begin
      r_pend <= w_issue;
      if (w_issue) begin
        r_raddr <= r_raddr + 1'b1;
        r_wleft <= r_wleft - 11'd1;
      end

      // Two-entry word queue: r_w0 is presented, r_w1 waits.
      if (w_pop) begin
        if (r_v1) begin
          r_w0 <= r_w1;
          r_v0 <= 1'b1;
          r_v1 <= r_pend;
          if (r_pend) r_w1 <= ep_rx_data_1;
        end else begin
          r_v0 <= r_pend;
          if (r_pend) r_w0 <= ep_rx_data_1;
        end
      end else if (r_pend) begin
        if (!r_v0) begin
          r_w0 <= ep_rx_data_1;
          r_v0 <= 1'b1;
        end else begin
          r_w1 <= ep_rx_data_1;
          r_v1 <= 1'b1;
        end
      end

      if (w_hs) begin
        r_cur <= r_cur + 11'd1;
        r_rem <= r_rem - 10'd1;
      end

      unique case (r_state)
        S_IDLE: begin
          r_ph <= 1'b0;
          if (cmd_valid) begin
            r_cur   <= cmd_addr;
            r_rem   <= cmd_len;
            r_raddr <= cmd_addr[10:LB];
            r_wleft <= w_nwords;
            r_state <= (cmd_len == 10'd0)
                     ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_ph    <= 1'b0;
            r_pend  <= 1'b0;
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
          end else if (r_ph) begin
            r_state <= S_STREAM;
            r_ph    <= 1'b0;
          end else begin
            r_ph <= 1'b1;
          end
        end
        S_STREAM: begin
          if (abort || (w_hs && w_lastb)) begin
            r_state <= abort ? S_IDLE : S_DONE;
            r_pend  <= 1'b0;
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_ep_rx_stream.sv
// tb_usb_ep_rx_stream: directed bench with scoreboard queues and
// negedge monitors for EPDW=16 and EPDW=32 instances.
`timescale 1ns/1ps
module tb_usb_ep_rx_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_cmd_valid = 1'b0;
  logic        a_abort = 1'b0;
  logic [10:0] a_cmd_addr = '0;
  logic [9:0]  a_cmd_len = '0;
  logic        a_cmd_ready, a_re, a_out_valid, a_out_last;
  logic        a_done, a_busy, a_out_ready;
  logic [9:0]  a_raddr;
  logic [15:0] a_rdata;
  logic [7:0]  a_out_data;

  logic        b_cmd_valid = 1'b0;
  logic        b_abort = 1'b0;
  logic [10:0] b_cmd_addr = '0;
  logic [9:0]  b_cmd_len = '0;
  logic        b_cmd_ready, b_re, b_out_valid, b_out_last;
  logic        b_done, b_busy;
  logic        b_out_ready = 1'b1;
  logic [8:0]  b_raddr;
  logic [31:0] b_rdata;
  logic [7:0]  b_out_data;

  logic [15:0] m16 [1024];
  logic [31:0] m32 [512];

  always @(posedge clk) if (a_re) a_rdata <= m16[a_raddr];
  always @(posedge clk) if (b_re) b_rdata <= m32[b_raddr];

  usb_ep_rx_stream #(.EPDW(16)) u_a (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_addr(a_cmd_addr), .cmd_len(a_cmd_len),
    .abort(a_abort),
    .ep_rx_addr_0(a_raddr), .ep_rx_re_0(a_re),
    .ep_rx_data_1(a_rdata),
    .out_data(a_out_data), .out_valid(a_out_valid),
    .out_last(a_out_last), .out_ready(a_out_ready),
    .done(a_done), .busy(a_busy)
  );

  usb_ep_rx_stream #(.EPDW(32)) u_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_addr(b_cmd_addr), .cmd_len(b_cmd_len),
    .abort(b_abort),
    .ep_rx_addr_0(b_raddr), .ep_rx_re_0(b_re),
    .ep_rx_data_1(b_rdata),
    .out_data(b_out_data), .out_valid(b_out_valid),
    .out_last(b_out_last), .out_ready(b_out_ready),
    .done(b_done), .busy(b_busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Pseudo-random sink back-pressure from a fixed-seed LFSR.
  bit rnd_mode = 1'b0;
  logic [7:0] lfsr;
  initial begin
    a_out_ready = 1'b1;
    lfsr = 8'hA5;
    forever begin
      @(posedge clk); #1;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      a_out_ready = rnd_mode ? lfsr[0] : 1'b1;
    end
  end

  logic [8:0] sbA [$];
  logic [8:0] sbB [$];

  function automatic logic [7:0] mbyte(input logic [10:0] ad);
    logic [15:0] w;
    w = m16[ad[10:1]];
    return ad[0] ? w[15:8] : w[7:0];
  endfunction

  task automatic push_mem(input logic [10:0] ad, input int ln,
                          input int cnt);
    for (int i = 0; i < cnt; i++)
      sbA.push_back({i == ln - 1, mbyte(ad + 11'(i))});
  endtask

  // Monitor A: scoreboard, stall stability, read occupancy.
  int rdA = 0, issA = 0, consA = 0, doneA = 0;
  logic [10:0] curA = '0;
  bit stallA = 1'b0;
  logic [8:0] prevA = '0;
  logic [8:0] expA;

  always @(negedge clk) begin
    if (!rst_n) begin
      sbA.delete();
      stallA = 1'b0;
      issA = 0;
      consA = 0;
    end else begin
      if (a_cmd_valid && a_cmd_ready) begin
        issA = 0; consA = 0; rdA = 0;
        curA = a_cmd_addr;
      end
      if (a_re) begin
        chk("rd_occupancy", 32'(issA - consA < 2), 1);
        issA++;
        rdA++;
      end
      if (stallA)
        chk("stall_hold", 32'({a_out_valid, a_out_last, a_out_data}),
            32'({1'b1, prevA}));
      if (a_out_valid && a_out_ready) begin
        if (sbA.size() == 0) begin
          n_chk++;
          $display("FAIL extra_byte: got %0h want none", a_out_data);
        end else begin
          expA = sbA.pop_front();
          chk("byte", 32'({a_out_last, a_out_data}), 32'(expA));
        end
        if (curA[0] || a_out_last) consA++;
        curA = curA + 11'd1;
      end
      if (a_done) doneA++;
      stallA = a_out_valid && !a_out_ready;
      prevA = {a_out_last, a_out_data};
    end
  end

  int rdB = 0;
  logic [8:0] expB;
  always @(negedge clk) begin
    if (!rst_n) begin
      sbB.delete();
    end else begin
      if (b_cmd_valid && b_cmd_ready) rdB = 0;
      if (b_re) rdB++;
      if (b_out_valid && b_out_ready) begin
        if (sbB.size() == 0) begin
          n_chk++;
          $display("FAIL extra_byte_b: got %0h want none", b_out_data);
        end else begin
          expB = sbB.pop_front();
          chk("byte_b", 32'({b_out_last, b_out_data}), 32'(expB));
        end
      end
    end
  end

  task automatic check_reset(input string t);
    chk({t, "_cmd_ready"}, 32'(a_cmd_ready), 1);
    chk({t, "_busy"}, 32'(a_busy), 0);
    chk({t, "_out_valid"}, 32'(a_out_valid), 0);
    chk({t, "_out_last"}, 32'(a_out_last), 0);
    chk({t, "_out_data"}, 32'(a_out_data), 0);
    chk({t, "_done"}, 32'(a_done), 0);
    chk({t, "_re"}, 32'(a_re), 0);
    chk({t, "_raddr"}, 32'(a_raddr), 0);
  endtask

  task automatic issue_a(input logic [10:0] ad, input logic [9:0] ln,
                         input string tag);
    int n;
    n = 0;
    while (!a_cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_idle"}, 32'(a_cmd_ready), 1);
    a_cmd_addr = ad;
    a_cmd_len = ln;
    a_cmd_valid = 1'b1;
    @(posedge clk); #1;
    a_cmd_valid = 1'b0;
    a_cmd_addr = ~ad;
    a_cmd_len = ~ln;
  endtask

  // Cycle index n counts from the handshake cycle (n=1 is the next).
  task automatic run_a(input logic [10:0] ad, input logic [9:0] ln,
                       input int e_first, input int e_done,
                       input int e_rd, input string tag);
    int n, first, dn;
    issue_a(ad, ln, tag);
    n = 1; first = -1; dn = -1;
    for (int k = 0; k < 600 && dn < 0; k++) begin
      if (a_out_valid && first < 0) first = n;
      if (a_done) dn = n;
      else begin
        @(posedge clk); #1; n++;
      end
    end
    chk({tag, "_done_seen"}, 32'(dn >= 0), 1);
    chk({tag, "_first"}, first, e_first);
    if (e_done >= 0) chk({tag, "_done_at"}, dn, e_done);
    chk({tag, "_reads"}, rdA, e_rd);
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, 32'(a_done), 0);
    chk({tag, "_back_idle"}, 32'(a_cmd_ready), 1);
    chk({tag, "_sb_empty"}, sbA.size(), 0);
  endtask

  task automatic run_abort();
    int nb, d0;
    d0 = doneA;
    push_mem(11'h080, 10, 5);
    issue_a(11'h080, 10'd10, "abort");
    nb = 0;
    for (int k = 0; k < 100; k++) begin
      if (a_out_valid && a_out_ready) nb++;
      if (nb == 5) break;
      @(posedge clk); #1;
    end
    chk("abort_reach5", nb, 5);
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    chk("abort_valid", 32'(a_out_valid), 0);
    chk("abort_re", 32'(a_re), 0);
    chk("abort_ready", 32'(a_cmd_ready), 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_no_done", doneA, d0);
    chk("abort_sb_empty", sbA.size(), 0);
  endtask

  task automatic run_rst();
    int d0;
    d0 = doneA;
    push_mem(11'h0C0, 10, 10);
    issue_a(11'h0C0, 10'd10, "rst");
    for (int k = 0; k < 20 && !a_out_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("rst_in_stream", 32'(a_out_valid), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_no_done", doneA, d0);
  endtask

  int n, first, dn;

  initial begin
    for (int i = 0; i < 1024; i++)
      m16[i] = {8'(i * 74 + 42), 8'(i * 74 + 5)};
    for (int i = 0; i < 512; i++)
      m32[i] = 32'(i * 32'h01010101) ^ 32'h5A5A5A5A;
    m16[10'h020] = 16'h2211;
    m16[10'h021] = 16'h4433;
    m16[10'h3FF] = 16'hAA00;
    m16[10'h000] = 16'h00BB;
    m32[9'h010]  = 32'h44332211;

    #12;
    check_reset("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    sbA.push_back(9'h011); sbA.push_back(9'h022);
    sbA.push_back(9'h033); sbA.push_back(9'h144);
    run_a(11'h040, 10'd4, 3, 7, 2, "aligned");

    sbA.push_back(9'h022); sbA.push_back(9'h033);
    sbA.push_back(9'h144);
    run_a(11'h041, 10'd3, 3, 6, 2, "unaligned");

    push_mem(11'h101, 16, 16);
    rnd_mode = 1'b1;
    run_a(11'h101, 10'd16, 3, -1, 9, "bp");
    rnd_mode = 1'b0;

    sbA.push_back(9'h0AA); sbA.push_back(9'h1BB);
    run_a(11'h7FF, 10'd2, 3, 5, 2, "wrap");

    run_a(11'h123, 10'd0, -1, 1, 0, "zero");

    run_abort();
    run_rst();

    sbA.push_back(9'h011); sbA.push_back(9'h022);
    sbA.push_back(9'h033); sbA.push_back(9'h144);
    run_a(11'h040, 10'd4, 3, 7, 2, "after_rst");

    sbB.push_back(9'h022); sbB.push_back(9'h033);
    sbB.push_back(9'h144);
    chk("b_idle", 32'(b_cmd_ready), 1);
    b_cmd_addr = 11'h041;
    b_cmd_len = 10'd3;
    b_cmd_valid = 1'b1;
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
    b_cmd_addr = '0;
    n = 1; first = -1; dn = -1;
    for (int k = 0; k < 100 && dn < 0; k++) begin
      if (b_out_valid && first < 0) first = n;
      if (b_done) dn = n;
      else begin
        @(posedge clk); #1; n++;
      end
    end
    chk("b32_first", first, 3);
    chk("b32_done_at", dn, 6);
    chk("b32_reads", rdB, 1);
    @(posedge clk); #1;
    chk("b32_sb_empty", sbB.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/usb_ep_rx_stream.md
Name: usb_ep_rx_stream

Overview:
- Downstream consumer of the USB core's EP RX buffer read port (`ep_rx_addr_0` / `ep_rx_re_0` / `ep_rx_data_1`).
- Given a byte address and length, reads the packet out of the RX buffer and presents it as a byte stream with valid/ready/last.
- Frees the CPU from word-level buffer reads; typical use is feeding a UART/FIFO bridge on the same clock as the buffer read side.

Parameters:
- EPDW, 16, EP buffer read data width in bits; legal values 16 or 32.
- EPAW, 11 - $clog2(EPDW/8), EP buffer word address width; derived, never overridden.

Ports:
- clk  input  1  clock; the same clock as the core's `ep_clk`.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block idle, command accepted when cmd_valid & cmd_ready.
- cmd_addr  input  11  start byte address in RX buffer.
- cmd_len  input  10  byte count, 0..1023.
- abort  input  1  cancel current command.
- ep_rx_addr_0  output  EPAW  buffer word address.
- ep_rx_re_0  output  1  buffer read enable.
- ep_rx_data_1  input  EPDW  buffer data, valid one cycle after `ep_rx_re_0`.
- out_data  output  8  stream byte.
- out_valid  output  1  stream byte valid.
- out_last  output  1  final byte of command.
- out_ready  input  1  sink accepts byte.
- done  output  1  one-cycle completion pulse.
- busy  output  1  command in progress (equals ~cmd_ready).

Behaviour:
- Reset values:
  - cmd_ready=1, busy=0.
  - out_valid=0, out_last=0, out_data=0, done=0.
  - ep_rx_re_0=0, ep_rx_addr_0=0.
  - State IDLE, all counters 0.
- Reset asserted mid-command drops everything immediately; no done pulse.
- States: IDLE, FETCH, STREAM, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr and len.
  - len=0 goes to DONE; otherwise goes to FETCH.
- FETCH:
  - One cycle with ep_rx_re_0=1 and ep_rx_addr_0 = cur_addr >> log2(EPDW/8).
  - Next cycle, capture ep_rx_data_1 into the word register, then go to STREAM.
- Byte lane:
  - Little-endian: byte lane = cur_addr[log2(EPDW/8)-1:0], lane 0 = bits [7:0].
  - Unaligned start skips lower lanes of the first word.
- Latency: first out_valid is asserted exactly 3 cycles after the cmd handshake cycle.
- STREAM:
  - out_valid=1 while bytes remain.
  - out_data, out_last stable while out_valid & ~out_ready (no combinational path from out_ready to out_data).
  - On each out_valid & out_ready: cur_addr+1, remaining-1.
- Prefetch: the next word is read while the current word's last lane is presented, so a sustained out_ready=1 yields one byte per clock with no bubbles, including across word boundaries.
- Back-pressure: prefetched word is held in a second register, at most 2 words buffered. ep_rx_re_0 never asserted while both registers are full.
- Address wrap: cur_addr is 11-bit and wraps 0x7FF→0x000; the word address wraps accordingly.
- Last byte:
  - out_last=1 with the byte where remaining==1.
  - After its handshake, out_valid drops and the block goes to DONE.
- DONE:
  - done=1 for exactly one cycle, cmd_ready=0.
  - Next cycle returns to IDLE with cmd_ready=1.
  - A new command can be accepted the cycle after done.
- abort:
  - Sampled in FETCH/STREAM/DONE.
  - Next cycle: out_valid=0, ep_rx_re_0=0, state IDLE, no done pulse.
  - A byte handshaken in the abort cycle counts as transferred.
  - abort in IDLE is ignored.
  - abort together with cmd_valid in IDLE: the command is accepted.
- cmd_addr, cmd_len are sampled only on handshake; later changes are ignored.
- ep_rx_re_0 is asserted only for reads whose data will be consumed. The exception is abort, where at most one read in flight is discarded.

Test Plan:
- Aligned read, EPDW=16: buffer word 0x20=0x2211, word 0x21=0x4433; cmd addr=0x040, len=4, out_ready=1.
  - Bytes 11,22,33,44 on consecutive cycles, first at handshake+3.
  - out_last only on 44; done pulses the cycle after 44; exactly 2 reads issued.
- Unaligned read: same buffer, addr=0x041, len=3.
  - Bytes 22,33,44; out_last on 44.
- Back-pressure: len=16, out_ready toggled pseudo-randomly (seed fixed).
  - All 16 bytes in order, data stable while stalled.
  - ep_rx_re_0 never issued with both word registers full.
- Wrap and zero length:
  - addr=0x7FF, len=2, word 0x3FF=0xAA00, word 0x000=0x00BB → bytes AA, BB.
  - len=0 → done pulse 1 cycle after handshake, no out_valid, no reads.
- Abort and reset mid-command:
  - abort after 5th byte of len=10 → out_valid low next cycle, no done, cmd_ready=1.
  - rst_n low in STREAM → all outputs at reset values immediately.
  - Following cmd addr=0x040 len=4 behaves as in the aligned-read test.
- EPDW=32:
  - word 0x10=0x44332211, addr=0x041, len=3 → bytes 22,33,44; one read.
